vsense_detector: RTL and testbench

Ventricular sense front-end directly upstream of the VVI pacemaker; its VPulse_eO drives the pacemaker's VPulse_eI.
- Qualifies a sampled ventricular electrogram against a fixed threshold, with consecutive-sample debounce and hysteresis.
- Emits one-cycle sense events.
- Blanks sensing after any paced or sensed beat, using the pacemaker's VPace_eO fed back as vpace_eI.

---
 rtl/vsense_pkg.sv | 36 +++
 rtl/vsense_blank_timer.sv | 38 +++
 rtl/vsense_detector.sv | 118 +++++++++++
 tb/tb_vsense_detector.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vsense_pkg.sv
// ============================================================================
// Module : vsense_pkg
// Brief  : Shared state type, default constants and rectifier for vsense_detector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vsense_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMING   = 2'd1,
    BLANK    = 2'd2,
    WAIT_LOW = 2'd3
  } vsense_state_t;

  localparam int VS_SAMPLE_W     = 12;
  localparam int VS_THRESH       = 400;
  localparam int VS_HYST         = 100;
  localparam int VS_MIN_CONSEC   = 3;
  localparam int VS_BLANK_CYCLES = 250;

  // Absolute value of a sign-extended w-bit sample; the most-negative code
  // saturates to the largest positive code so it cannot wrap back to negative.
  function automatic logic [31:0] vsense_magnitude(input logic signed [31:0] s,
                                                   input int w);
    logic signed [31:0] lim;
    lim = (32'sd1 <<< (w - 1)) - 32'sd1;
    if (s >= 0)    return s;
    if (s < -lim)  return lim;
    return -s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vsense_blank_timer.sv
// ============================================================================
// Module : vsense_blank_timer
// Brief  : Loadable down-counter; done marks the final counted cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vsense_blank_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      busy  <= 1'b0;
    end else if (load) begin
      count <= load_value;
      busy  <= 1'b1;
    end else if (busy) begin
      if (count == '0) busy  <= 1'b0;
      else             count <= count - 1'b1;
    end
  end

  assign done = busy && (count == '0);

endmodule

`default_nettype wire

// File: rtl/vsense_detector.sv
// ============================================================================
// Module : vsense_detector
// Brief  : Ventricular sense qualifier with debounce, hysteresis and blanking.
//          Optional macro VSENSE_STATS_EN adds a saturating sense counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vsense_detector
  import vsense_pkg::*;
#(
  parameter int SAMPLE_W     = VS_SAMPLE_W,
  parameter int THRESH       = VS_THRESH,
  parameter int HYST         = VS_HYST,
  parameter int MIN_CONSEC   = VS_MIN_CONSEC,
  parameter int BLANK_CYCLES = VS_BLANK_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample_data,
  input  logic                       vpace_eI,
  output logic                       VPulse_eO,
  output logic                       blanking_o
`ifdef VSENSE_STATS_EN
  ,
  output logic [15:0]                sense_count_o
`endif
);

  localparam int CW = $clog2(MIN_CONSEC + 1);
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  vsense_state_t state;
  logic [CW-1:0] consec;
  logic [31:0]   mag;
  logic          sup;
  logic          low;
  logic          sense_now;
  logic          timer_busy;
  logic          timer_done;

  assign mag = vsense_magnitude(32'(sample_data), SAMPLE_W);
  assign sup = mag >= 32'(THRESH);
  assign low = mag < 32'(THRESH - HYST);

  // A pace on the same edge suppresses an otherwise completed sense.
  assign sense_now = !vpace_eI && sample_valid && sup &&
                     (((state == IDLE) && (MIN_CONSEC == 1)) ||
                      ((state == ARMING) && (consec == CW'(MIN_CONSEC - 1))));

  vsense_blank_timer #(
    .WIDTH(BW)
  ) u_blank_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (vpace_eI || sense_now),
    .load_value(BW'(BLANK_CYCLES - 1)),
    .busy      (timer_busy),
    .done      (timer_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      consec     <= '0;
      VPulse_eO  <= 1'b0;
      blanking_o <= 1'b0;
    end else begin
      VPulse_eO <= 1'b0;
      if (vpace_eI || sense_now) begin
        state      <= BLANK;
        consec     <= '0;
        blanking_o <= 1'b1;
        VPulse_eO  <= sense_now;
      end else begin
        case (state)
          IDLE: begin
            if (sample_valid && sup) begin
              consec <= CW'(1);
              state  <= ARMING;
            end
          end
          ARMING: begin
            if (sample_valid) begin
              if (sup) begin
                consec <= consec + 1'b1;
              end else begin
                consec <= '0;
                state  <= IDLE;
              end
            end
          end
          BLANK: begin
            if (timer_done || !timer_busy) begin
              state      <= WAIT_LOW;
              blanking_o <= 1'b0;
            end
          end
          WAIT_LOW: begin
            if (sample_valid && low) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef VSENSE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  sense_count_o <= '0;
    else if (VPulse_eO && sense_count_o != 16'hFFFF) sense_count_o <= sense_count_o + 16'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vsense_detector.sv
// ============================================================================
// Module : tb_vsense_detector
// Brief  : Directed and randomized bench for vsense_detector with a reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vsense_detector;

  localparam int THRESH = 400;
  localparam int LOWLIM = 300;
  localparam int NCONS  = 3;
  localparam int NBLANK = 250;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sample_valid = 1'b0;
  logic signed [11:0] sample_data = '0;
  logic vpace_eI = 1'b0;
  logic VPulse_eO;
  logic blanking_o;
`ifdef VSENSE_STATS_EN
  logic [15:0] sense_count_o;
`endif

  int checks = 0;
  int passed = 0;

  // Reference model: length of the current supra-threshold run, cycles of
  // blanking still owed, and whether a return-to-low sample is still awaited.
  int run = 0;
  int blank_left = 0;
  bit wait_low = 1'b0;
  bit exp_pulse = 1'b0;
  int exp_count = 0;

  vsense_detector dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .vpace_eI     (vpace_eI),
    .VPulse_eO    (VPulse_eO),
    .blanking_o   (blanking_o)
`ifdef VSENSE_STATS_EN
    ,
    .sense_count_o(sense_count_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic int mag_of(input logic signed [11:0] d);
    int v;
    v = int'(d);
    if (v < 0) v = -v;
    if (v > 2047) v = 2047;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_edge(input bit v, input logic signed [11:0] d, input bit p);
    if (exp_pulse && exp_count < 65535) exp_count++;
    exp_pulse = 1'b0;
    if (p) begin
      blank_left = NBLANK;
      run = 0;
      wait_low = 1'b0;
    end else if (blank_left > 0) begin
      blank_left--;
      if (blank_left == 0) wait_low = 1'b1;
    end else if (wait_low) begin
      if (v && mag_of(d) < LOWLIM) wait_low = 1'b0;
    end else if (v) begin
      if (mag_of(d) >= THRESH) begin
        run++;
        if (run == NCONS) begin
          exp_pulse = 1'b1;
          blank_left = NBLANK;
          run = 0;
        end
      end else begin
        run = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_pulse"}, 32'(VPulse_eO), 32'(exp_pulse));
    chk({tag, "_blank"}, 32'(blanking_o), 32'(blank_left > 0));
`ifdef VSENSE_STATS_EN
    chk({tag, "_count"}, 32'(sense_count_o), 32'(exp_count));
`endif
  endtask

  task automatic cyc(input bit v, input int d, input bit p, input string tag);
    sample_valid = v;
    sample_data  = d[11:0];
    vpace_eI     = p;
    @(posedge clk);
    model_edge(v, d[11:0], p);
    #1;
    check_outputs(tag);
  endtask

  task automatic samp(input int d, input string tag);
    cyc(1'b1, d, 1'b0, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, tag);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic async_reset(input string tag);
    sample_valid = 1'b0;
    vpace_eI = 1'b0;
    #2 reset = 1'b0;
    #1;
    run = 0; blank_left = 0; wait_low = 1'b0; exp_pulse = 1'b0; exp_count = 0;
    check_outputs(tag);
    #2 reset = 1'b1;
  endtask

  initial begin
    int bc;
    int k;
    int m;
    int d;

    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    #4 reset = 1'b1;

    // Basic sense and exact blanking length
    samp(450, "s1"); samp(450, "s1"); samp(450, "s1");
    chk("s1_pulse_now", 32'(VPulse_eO), 32'd1);
    bc = int'(blanking_o);
    for (int i = 0; i < 259; i++) begin
      cyc(1'b0, 0, 1'b0, "s1_blank");
      bc += int'(blanking_o);
    end
    chk("s1_blank_len", 32'(bc), 32'd250);
    samp(250, "s1_exit");

    // Debounce broken by a sub-threshold sample
    samp(450, "s2"); samp(450, "s2"); samp(300, "s2"); samp(450, "s2");
    samp(100, "s2");

    // Negative polarity with most-negative saturation
    samp(-2048, "s3"); samp(-500, "s3"); samp(-410, "s3");
    chk("s3_pulse_now", 32'(VPulse_eO), 32'd1);
    idle(255, "s3_blank");

    // Hysteresis: mid-band and boundary samples keep WAIT_LOW
    for (int i = 0; i < 5; i++) samp(350, "s4_band");
    samp(300, "s4_edge");
    samp(450, "s4"); samp(450, "s4"); samp(450, "s4");
    chk("s4_no_retrig", 32'(VPulse_eO), 32'd0);
    samp(299, "s4_low");
    samp(400, "s4"); samp(-400, "s4"); samp(400, "s4");
    chk("s4_thresh_edge", 32'(VPulse_eO), 32'd1);
    idle(252, "s4_blank");
    samp(250, "s4_exit");

    // Pace on the edge that would complete a sense, then a restart mid-blank
    samp(450, "s5"); samp(450, "s5");
    cyc(1'b1, 450, 1'b1, "s5_pace");
    chk("s5_pulse_suppressed", 32'(VPulse_eO), 32'd0);
    chk("s5_blank_now", 32'(blanking_o), 32'd1);
    idle(99, "s5_blank");
    cyc(1'b0, 0, 1'b1, "s5_repace");
    bc = int'(blanking_o);
    for (int i = 0; i < 259; i++) begin
      cyc(1'b1, 450, 1'b0, "s5_blank2");
      bc += int'(blanking_o);
    end
    chk("s5_blank2_len", 32'(bc), 32'd250);
    samp(0, "s5_exit");

    // Reset during the pulse cycle, during blanking and mid-arming
    samp(450, "s6"); samp(450, "s6"); samp(450, "s6");
    async_reset("s6_rst_pulse");
    samp(450, "s6"); samp(450, "s6"); samp(450, "s6");
    idle(10, "s6_blank");
    async_reset("s6_rst_blank");
    samp(450, "s6_arm"); samp(450, "s6_arm");
    async_reset("s6_rst_arm");
    samp(450, "s6_after"); samp(450, "s6_after");
    chk("s6_no_stale_run", 32'(VPulse_eO), 32'd0);
    samp(450, "s6_after");

    // Randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      k = int'($urandom_range(0, 9));
      if (k < 5)      m = int'($urandom_range(400, 2047));
      else if (k < 7) m = int'($urandom_range(300, 399));
      else if (k < 9) m = int'($urandom_range(0, 299));
      else            m = 2048;
      d = ($urandom_range(0, 1) == 1 || m == 2048) ? -m : m;
      cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 299) == 0, "rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
